// File: rtl/ring_counter_param_pkg.sv
// Shared encodings for the ring/Johnson counter and its legality checker.
package ring_counter_param_pkg;

  // Counting mode select
  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Shift direction select
  localparam logic DIR_UP       = 1'b0;  // toward MSB
  localparam logic DIR_DOWN     = 1'b1;  // toward LSB

endpackage

// File: rtl/ring_counter_param_checker.sv
// Combinational legality check of a counter code for the selected mode.
module ring_code_checker
  import ring_counter_param_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] code,
  input  logic             mode,
  output logic             legal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             ring_ok;
  logic             therm_ok;
  logic [WIDTH-1:0] norm;

  // Ring: exactly one bit set. Johnson: thermometer or its complement;
  // complements have bit0 clear, so inverting them yields a thermometer.
  always_comb begin
    ring_ok  = (code != '0) && ((code & (code - ONE)) == '0);
    norm     = code[0] ? code : ~code;
    therm_ok = ((norm & (norm + ONE)) == '0);
    legal    = (mode == MODE_JOHNSON) ? therm_ok : ring_ok;
  end

endmodule

// File: rtl/ring_counter_param.sv
// Parameterised ring / Johnson counter with phase tracking and repair.
module ring_counter_param
  import ring_counter_param_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(1),
  parameter bit               SELF_CORRECT = 1'b1,
  localparam int              PW           = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [PW-1:0]    PH_ONE    = PW'(1);
  localparam logic [PW-1:0]    RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    JOHN_LAST = PW'(2*WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             mode_q;

  logic             legal;
  logic             mode_chg;
  logic             shift_in;
  logic [WIDTH-1:0] stepped;
  logic [PW-1:0]    last;

  ring_code_checker #(.WIDTH(WIDTH)) u_chk (
    .code  (out_q),
    .mode  (mode),
    .legal (legal)
  );

  assign illegal = ~legal;
  assign out     = out_q;
  assign phase   = phase_q;
  assign wrap    = wrap_q;

  // Shifted code and period bookkeeping for the currently selected mode
  always_comb begin
    mode_chg = (mode != mode_q);
    last     = (mode == MODE_JOHNSON) ? JOHN_LAST : RING_LAST;
    shift_in = (dir == DIR_UP) ? out_q[WIDTH-1] : out_q[0];
    if (mode == MODE_JOHNSON) shift_in = ~shift_in;
    stepped  = (dir == DIR_UP) ? {out_q[WIDTH-2:0], shift_in}
                               : {shift_in, out_q[WIDTH-1:1]};
  end

  // Next state: load beats step beats hold; a mode switch restarts phase
  always_comb begin
    out_d   = out_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (mode_chg) phase_d = '0;
    if (load) begin
      out_d   = preset;
      phase_d = '0;
    end else if (en) begin
      if (illegal && SELF_CORRECT) begin
        out_d   = (mode == MODE_JOHNSON) ? '0 : ONE;
        phase_d = '0;
      end else begin
        out_d = stepped;
        if (!mode_chg) begin
          if (dir == DIR_UP) begin
            wrap_d  = (phase_q == last);
            phase_d = (phase_q == last) ? '0 : phase_q + PH_ONE;
          end else begin
            wrap_d  = (phase_q == '0);
            phase_d = (phase_q == '0) ? last : phase_q - PH_ONE;
          end
        end
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q   <= RESET_VALUE;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= MODE_RING;
    end else begin
      out_q   <= out_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode;
    end
  end

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench: two DUTs (repair on/off) against a behavioural model.
module tb_ring_counter_param;
  import ring_counter_param_pkg::*;

  localparam int W    = 4;
  localparam int PW   = $clog2(2*W);
  localparam int MASK = (1 << W) - 1;
  localparam int RV   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [W-1:0]  preset = '0;
  logic [W-1:0]  out1, out0;
  logic [PW-1:0] ph1, ph0;
  logic          wrap1, wrap0, ill1, ill0;

  always #5 clk = ~clk;

  ring_counter_param #(.WIDTH(W), .RESET_VALUE(4'b0001), .SELF_CORRECT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .preset(preset), .out(out1), .phase(ph1), .wrap(wrap1), .illegal(ill1));

  ring_counter_param #(.WIDTH(W), .RESET_VALUE(4'b0001), .SELF_CORRECT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .preset(preset), .out(out0), .phase(ph0), .wrap(wrap0), .illegal(ill0));

  typedef struct {
    int out1, ph1, wrap1, ill1;
    int out0, ph0, wrap0, ill0;
    bit pin; int pout, pph, pwrap;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0, fails = 0;

  // model state: index 1 = repairing counter, 0 = non-repairing
  int m_out[2], m_ph[2], m_wrap[2];
  int m_modeq;

  function automatic bit legal_m(input int c, input int md);
    if (md == 0) return $countones(c[W-1:0]) == 1;
    for (int k = 0; k <= W; k++) begin
      int t = (1 << k) - 1;
      if (c == t || c == (~t & MASK)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int rot(input int c, input int md, input int d);
    int fb;
    if (d == 0) begin
      fb = (c >> (W-1)) & 1;
      if (md != 0) fb = fb ^ 1;
      return ((c << 1) | fb) & MASK;
    end
    fb = c & 1;
    if (md != 0) fb = fb ^ 1;
    return (c >> 1) | (fb << (W-1));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus; the model predicts the state after the edge
  task automatic cyc(input int r, input int ld, input int e, input int md,
                     input int d, input int pv, input bit pin = 1'b0,
                     input int pout = 0, input int pph = 0, input int pwrap = 0);
    exp_t x;
    bit   chg;
    int   per;
    @(negedge clk);
    rst = r[0]; load = ld[0]; en = e[0]; mode = md[0]; dir = d[0];
    preset = pv[W-1:0];
    chg = (md != m_modeq);
    per = (md != 0) ? 2*W : W;
    for (int i = 0; i < 2; i++) begin
      if (r == 0) begin
        m_out[i] = RV; m_ph[i] = 0; m_wrap[i] = 0;
      end else if (ld != 0) begin
        m_out[i] = pv & MASK; m_ph[i] = 0; m_wrap[i] = 0;
      end else if (e != 0) begin
        if (i == 1 && !legal_m(m_out[i], md)) begin
          m_out[i] = (md != 0) ? 0 : 1; m_ph[i] = 0; m_wrap[i] = 0;
        end else begin
          m_out[i] = rot(m_out[i], md, d);
          if (chg) begin
            m_ph[i] = 0; m_wrap[i] = 0;
          end else if (d == 0) begin
            m_wrap[i] = (m_ph[i] == per-1); m_ph[i] = (m_ph[i] + 1) % per;
          end else begin
            m_wrap[i] = (m_ph[i] == 0); m_ph[i] = (m_ph[i] + per - 1) % per;
          end
        end
      end else begin
        m_wrap[i] = 0;
        if (chg) m_ph[i] = 0;
      end
    end
    m_modeq = (r == 0) ? 0 : md;
    x.out1 = m_out[1]; x.ph1 = m_ph[1]; x.wrap1 = m_wrap[1];
    x.ill1 = !legal_m(m_out[1], md);
    x.out0 = m_out[0]; x.ph0 = m_ph[0]; x.wrap0 = m_wrap[0];
    x.ill0 = !legal_m(m_out[0], md);
    x.pin = pin; x.pout = pout; x.pph = pph; x.pwrap = pwrap;
    sbq.push_back(x);
  endtask

  // monitor: every edge the DUTs present a new registered state
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        x = sbq.pop_front();
        chk("out_sc1",   out1,  x.out1);
        chk("phase_sc1", ph1,   x.ph1);
        chk("wrap_sc1",  wrap1, x.wrap1);
        chk("ill_sc1",   ill1,  x.ill1);
        chk("out_sc0",   out0,  x.out0);
        chk("phase_sc0", ph0,   x.ph0);
        chk("wrap_sc0",  wrap0, x.wrap0);
        chk("ill_sc0",   ill0,  x.ill0);
        if (x.pin) begin
          chk("pin_out",   out1,  x.pout);
          chk("pin_phase", ph1,   x.pph);
          chk("pin_wrap",  wrap1, x.pwrap);
        end
      end
    end
  end

  initial begin
    int cm, cd;
    m_out = '{RV, RV}; m_ph = '{0, 0}; m_wrap = '{0, 0}; m_modeq = 0;

    // ring up, one full period
    cyc(0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0010, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0100, 2, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b1000, 3, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0001, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0);

    // Johnson full period from 0000
    cyc(1, 1, 0, 1, 0, 4'b0000, 1, 4'b0000, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b0001, 1, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b0011, 2, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b0111, 3, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b1111, 4, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b1110, 5, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b1100, 6, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b1000, 7, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b0000, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 1, 4'b0000, 0, 0);

    // ring down then direction flip
    cyc(0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 1, 4'b1000, 3, 1);
    cyc(1, 0, 1, 0, 1, 0, 1, 4'b0100, 2, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b1000, 3, 0);

    // illegal ring load and repair (non-repairing copy goes to 1010)
    cyc(1, 1, 0, 0, 0, 4'b0101, 1, 4'b0101, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0001, 0, 0);

    // load beats en; reset beats load; hold
    cyc(1, 1, 1, 0, 0, 4'b0100, 1, 4'b0100, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b1000, 1, 0);
    cyc(0, 1, 1, 0, 0, 4'b1111, 1, 4'b0001, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0010, 1, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 1, 4'b0010, 1, 0);

    // ring to Johnson switch, then Johnson repair of a one-hot code
    cyc(1, 1, 0, 0, 0, 4'b0010, 1, 4'b0010, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 4'b0100, 1, 0);
    cyc(1, 0, 0, 1, 0, 0, 1, 4'b0100, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 1, 4'b0000, 0, 0);

    // randomized traffic
    cm = 0; cd = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) cm = cm ^ 1;
      if ($urandom_range(0, 3) == 0)  cd = cd ^ 1;
      cyc(($urandom_range(0, 59) != 0) ? 1 : 0,
          ($urandom_range(0, 11) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          cm, cd, int'($urandom & MASK));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
